// File: rtl/gameconsole_pkg.sv
// Shared game console constants plus the capture FIFO entry and address helper.
package gameconsole_pkg;

    localparam int unsigned SCREEN_W      = 320;
    localparam int unsigned SCREEN_H      = 240;
    localparam int unsigned SCREEN_HBLANK = 64;
    localparam int unsigned SCREEN_VBLANK = 22;

    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 32;
    localparam int unsigned COORD_W   = 9;

    localparam logic [COORD_W-1:0] SCREEN_W_C = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] SCREEN_H_C = COORD_W'(SCREEN_H);
    localparam logic [COORD_W-1:0] LAST_X     = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y     = COORD_W'(SCREEN_H - 1);

    typedef struct packed {
        logic                 last;
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } cap_entry_t;

    // Linear framebuffer word address; 320 = 256 + 64 avoids a multiplier.
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        if (SCREEN_W == 320) begin
            return (FB_ADDR_W'(y) << 8) + (FB_ADDR_W'(y) << 6) + FB_ADDR_W'(x);
        end else begin
            return FB_ADDR_W'(y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(x);
        end
    endfunction

endpackage

// File: rtl/vpu_video_capture_if.sv
// Framebuffer write port: valid/ready handshake carrying address and pixel data.
interface vpu_video_capture_if #(
    parameter int unsigned ADDR_W = gameconsole_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W = gameconsole_pkg::FB_DATA_W
);
    logic              fb_valid;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;

    modport master (output fb_valid, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_valid, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/vpu_cap_fifo.sv
// Synchronous FIFO whose head entry sits in its own register so the
// consumer sees flop outputs only.
module vpu_cap_fifo
    import gameconsole_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = cap_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output logic o_valid,
    output T     o_head,
    output logic o_full_c
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 r_mem [DEPTH];
    T                 r_head;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    T                 w_head_nxt;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign o_full_c = (r_count == CNT_W'(DEPTH));
    assign w_pop    = i_pop && r_valid;
    assign w_push   = i_push && (!o_full_c || w_pop);
    assign o_valid  = r_valid;
    assign o_head   = r_head;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Next head: following stored entry on pop, or bypass the incoming entry when it becomes the head.
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_count >= CNT_W'(2)) begin
                w_head_nxt = r_mem[r_rd_ptr + PTR_W'(1)];
            end else if (w_push) begin
                w_head_nxt = i_din;
            end
        end else if (!r_valid && w_push) begin
            w_head_nxt = i_din;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_head  <= w_head_nxt;
        end
    end

endmodule

// File: rtl/vpu_video_capture.sv
// Video sink: rebuilds pixel x/y from the VPU strobes and streams visible
// pixels of enabled frames into a framebuffer write port.
module vpu_video_capture #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FB_ADDR_W  = gameconsole_pkg::FB_ADDR_W,
    parameter int unsigned FB_DATA_W  = gameconsole_pkg::FB_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dot_clk,
    input  logic [31:0]         color,
    input  logic                hsync,
    input  logic                vsync,
    input  logic                cap_en,
    input  logic                ovf_clr,
    vpu_video_capture_if.master fb,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                overflow,
    output logic                capturing
);
    import gameconsole_pkg::*;

    logic               r_dot;
    logic               r_hs;
    logic               r_vs;
    logic               w_dot_edge;
    logic               w_hs_edge;
    logic               w_vs_edge;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_armed;
    logic               r_capturing;
    logic               w_visible;
    cap_entry_t         w_entry;
    logic               r_push;
    cap_entry_t         r_entry;
    logic               w_fifo_valid;
    logic               w_fifo_full_c;
    cap_entry_t         w_head;
    logic               w_pop;
    logic               w_drop;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;
    logic               r_overflow;

    assign w_dot_edge = dot_clk && !r_dot;
    assign w_hs_edge  = hsync && !r_hs;
    assign w_vs_edge  = vsync && !r_vs;

    // Pixels coinciding with a sync edge are ignored.
    assign w_visible = w_dot_edge && !w_hs_edge && !w_vs_edge && r_armed && r_capturing
                    && (r_x < SCREEN_W_C) && (r_y < SCREEN_H_C);

    assign w_pop  = w_fifo_valid && fb.fb_ready;
    assign w_drop = r_push && w_fifo_full_c && !w_pop;

    // Entry for the pixel at the current coordinates.
    always_comb begin
        w_entry      = '0;
        w_entry.last = (r_x == LAST_X) && (r_y == LAST_Y);
        w_entry.addr = pix_addr(r_x, r_y);
        w_entry.data = color;
    end

    // One-stage input history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dot <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
        end else begin
            r_dot <= dot_clk;
            r_hs  <= hsync;
            r_vs  <= vsync;
        end
    end

    // Raster position and per-frame capture decision; vsync beats hsync beats dot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= '0;
            r_y         <= '0;
            r_armed     <= 1'b0;
            r_capturing <= 1'b0;
        end else if (w_vs_edge) begin
            r_x         <= '0;
            r_y         <= '0;
            r_armed     <= 1'b1;
            r_capturing <= cap_en;
        end else if (w_hs_edge) begin
            r_x <= '0;
            if (r_y != '1) r_y <= r_y + COORD_W'(1);
        end else if (w_dot_edge) begin
            if (r_x != '1) r_x <= r_x + COORD_W'(1);
        end
    end

    // Push request stage between pixel detection and the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push  <= 1'b0;
            r_entry <= '0;
        end else begin
            r_push <= w_visible;
            if (w_visible) r_entry <= w_entry;
        end
    end

    vpu_cap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (cap_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (r_push),
        .i_din    (r_entry),
        .i_pop    (fb.fb_ready),
        .o_valid  (w_fifo_valid),
        .o_head   (w_head),
        .o_full_c (w_fifo_full_c)
    );

    // Frame completion and sticky drop status; a drop wins over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_head.last;
            if (w_pop && w_head.last) r_frame_count <= r_frame_count + 16'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign fb.fb_valid = w_fifo_valid;
    assign fb.fb_addr  = FB_ADDR_W'(w_head.addr);
    assign fb.fb_data  = FB_DATA_W'(w_head.data);
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign capturing   = r_capturing;

endmodule

// File: tb/tb_vpu_video_capture.sv
// Directed bench for vpu_video_capture.
module tb_vpu_video_capture;

    logic        clk;
    logic        rst_n;
    logic        dot_clk;
    logic [31:0] color;
    logic        hsync;
    logic        vsync;
    logic        cap_en;
    logic        ovf_clr;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic        capturing;

    vpu_video_capture_if #(.ADDR_W(17), .DATA_W(32)) fb_if ();

    vpu_video_capture #(
        .FIFO_DEPTH (8),
        .FB_ADDR_W  (17),
        .FB_DATA_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dot_clk     (dot_clk),
        .color       (color),
        .hsync       (hsync),
        .vsync       (vsync),
        .cap_en      (cap_en),
        .ovf_clr     (ovf_clr),
        .fb          (fb_if),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow),
        .capturing   (capturing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    logic [16:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Record accepted writes and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (fb_if.fb_valid && fb_if.fb_ready) begin
            wr_addr_q.push_back(fb_if.fb_addr);
            wr_data_q.push_back(fb_if.fb_data);
        end
        if (frame_done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dot(input logic [31:0] col);
        color   = col;
        dot_clk = 1'b1;
        tick(1);
        dot_clk = 1'b0;
        tick(3);
    endtask

    task automatic vsync_pulse(input logic en);
        cap_en = en;
        vsync  = 1'b1;
        tick(2);
        vsync  = 1'b0;
        tick(2);
    endtask

    task automatic hsync_pulse();
        hsync = 1'b1;
        tick(2);
        hsync = 1'b0;
        tick(2);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        n_done = 0;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; dot_clk = 1'b0; color = '0; hsync = 1'b0; vsync = 1'b0;
        cap_en = 1'b1; ovf_clr = 1'b0; fb_if.fb_ready = 1'b1;
        tick(3);
        chk("rst_fb_valid",    32'(fb_if.fb_valid), 32'(0));
        chk("rst_overflow",    32'(overflow),       32'(0));
        chk("rst_capturing",   32'(capturing),      32'(0));
        chk("rst_frame_count", 32'(frame_count),    32'(0));
        chk("rst_frame_done",  32'(frame_done),     32'(0));
        rst_n = 1'b1;
        tick(2);

        // Strobes before the first vsync are not captured.
        for (int i = 0; i < 5; i++) dot(32'h1111_0000 + 32'(i));
        tick(4);
        chk("pre_vsync_writes", 32'(wr_addr_q.size()), 32'(0));

        // One full line.
        vsync_pulse(1'b1);
        chk("line_capturing", 32'(capturing), 32'(1));
        clear_log();
        for (int i = 0; i < 320; i++) dot(32'hC0DE_0000 + 32'(i));
        tick(5);
        chk("line_writes", 32'(wr_addr_q.size()), 32'(320));
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 17'(i) || wr_data_q[i] !== 32'hC0DE_0000 + 32'(i)) bad++;
        chk("line_addr_data", 32'(bad), 32'(0));
        chk("line_overflow", 32'(overflow), 32'(0));
        chk("line_no_done", 32'(n_done), 32'(0));

        // Frame reaching the last pixel: two pixels per line on rows 0..238, then a full row 239.
        vsync_pulse(1'b1);
        clear_log();
        for (int y = 0; y < 239; y++) begin
            dot(32'(y * 1000));
            dot(32'(y * 1000 + 1));
            hsync_pulse();
        end
        for (int x = 0; x < 320; x++) dot(32'(239 * 1000 + x));
        tick(5);
        chk("frame_writes", 32'(wr_addr_q.size()), 32'(798));
        if (wr_addr_q.size() == 798) begin
            chk("frame_row1_addr", 32'(wr_addr_q[2]),   32'(320));
            chk("frame_last_addr", 32'(wr_addr_q[797]), 32'(76799));
            chk("frame_last_data", wr_data_q[797],      32'(239319));
        end
        chk("frame_done_pulses", 32'(n_done),      32'(1));
        chk("frame_count_1",     32'(frame_count), 32'(1));

        // Stall: 20 pixels into an 8-deep FIFO.
        vsync_pulse(1'b1);
        clear_log();
        fb_if.fb_ready = 1'b0;
        for (int i = 0; i < 10; i++) dot(32'hAB00_0000 + 32'(i));
        chk("stall_addr_mid", 32'(fb_if.fb_addr), 32'(0));
        for (int i = 10; i < 20; i++) dot(32'hAB00_0000 + 32'(i));
        chk("stall_addr_end", 32'(fb_if.fb_addr),  32'(0));
        chk("stall_data_end", fb_if.fb_data,        32'hAB00_0000);
        chk("stall_valid",    32'(fb_if.fb_valid),  32'(1));
        chk("stall_overflow", 32'(overflow),        32'(1));
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'(0));
        fb_if.fb_ready = 1'b1;
        tick(12);
        chk("stall_drain_writes", 32'(wr_addr_q.size()), 32'(8));
        if (wr_addr_q.size() == 8)
            chk("stall_drain_last_addr", 32'(wr_addr_q[7]), 32'(7));

        // Clear coincident with a new drop: the drop wins.
        fb_if.fb_ready = 1'b0;
        for (int i = 0; i < 8; i++) dot(32'hCD00_0000 + 32'(i));
        chk("refill_no_overflow", 32'(overflow), 32'(0));
        color   = 32'hCD00_0008;
        dot_clk = 1'b1;
        tick(1);
        dot_clk = 1'b0;
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("clr_vs_drop", 32'(overflow), 32'(1));
        tick(2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        fb_if.fb_ready = 1'b1;
        tick(12);

        // Capture disabled at vsync; enabling mid-frame changes nothing.
        clear_log();
        vsync_pulse(1'b0);
        chk("dis_capturing", 32'(capturing), 32'(0));
        for (int i = 0; i < 10; i++) dot(32'h5500_0000 + 32'(i));
        hsync_pulse();
        cap_en = 1'b1;
        for (int i = 0; i < 5; i++) dot(32'h5600_0000 + 32'(i));
        tick(5);
        chk("dis_writes",          32'(wr_addr_q.size()), 32'(0));
        chk("dis_capturing_after", 32'(capturing),        32'(0));
        vsync_pulse(1'b1);
        cap_en = 1'b0;
        for (int i = 0; i < 3; i++) dot(32'h5700_0000 + 32'(i));
        tick(5);
        chk("en_writes",        32'(wr_addr_q.size()), 32'(3));
        chk("en_capturing_hold", 32'(capturing),       32'(1));

        // Reset with five entries pending.
        clear_log();
        cap_en = 1'b1;
        fb_if.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) dot(32'h7700_0000 + 32'(i));
        chk("pending_valid", 32'(fb_if.fb_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(fb_if.fb_valid), 32'(0));
        tick(2);
        rst_n = 1'b1;
        fb_if.fb_ready = 1'b1;
        tick(2);
        chk("rst_mid_count", 32'(frame_count), 32'(0));
        for (int i = 0; i < 5; i++) dot(32'h7800_0000 + 32'(i));
        tick(5);
        chk("rst_mid_no_writes", 32'(wr_addr_q.size()), 32'(0));
        vsync_pulse(1'b1);
        for (int i = 0; i < 3; i++) dot(32'h7900_0000 + 32'(i));
        tick(5);
        chk("rst_rearm_writes", 32'(wr_addr_q.size()), 32'(3));
        if (wr_addr_q.size() == 3)
            chk("rst_rearm_addr", 32'(wr_addr_q[2]), 32'(2));
        chk("rst_mid_no_done", 32'(n_done), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
